conv_engine_kxk: RTL and testbench
==================================

Name: conv_engine_kxk

Overview:
- Streaming 2-D convolution engine; successor to the fixed 5x5 engine.
- Parametrised in map size, kernel size, stride, data/accumulator width.
- Adds per-frame bias, optional ReLU, input-ready indication, weight/bias latching at start, and a flush phase so the last outputs of a frame are always written.
- Consumes one raster-order frame (row-major, one pixel per accepted beat) and writes each output to a result BRAM at sequential addresses.

Parameters:
- MAPSIZE, 32: input frame width and height in pixels.
- KSIZE, 5: kernel width and height. Legal range 2..MAPSIZE.
- STRIDE, 1: window step in both dimensions. Legal values 1 or 2.
- DATA_W, 8: signed pixel and weight width.
- ACC_W, 32: signed accumulator, bias and result width. Must be at least 2*DATA_W+$clog2(KSIZE*KSIZE).
- Derived localparam OUT_DIM = (MAPSIZE-KSIZE)/STRIDE+1.
- Derived localparam OUT_COUNT = OUT_DIM*OUT_DIM.
- Derived localparam ADDR_W = $clog2(OUT_COUNT), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame. Honoured only in IDLE.
- mode_relu  in  1  clamp negative results to 0. Latched at start.
- data_valid_in  in  1  pixel_in is valid this cycle.
- pixel_in  in  DATA_W  signed pixel.
- in_ready  out  1  engine accepts pixels. High only in STREAM.
- weights  in  [KSIZE][KSIZE][DATA_W]  signed kernel; [row][col], [0][0] is top-left. Latched at start.
- bias  in  ACC_W  signed bias. Latched at start.
- mem_wr_addr  out  ADDR_W  result address.
- mem_wr_data  out  ACC_W  signed result.
- mem_wr_en  out  1  one-cycle write strobe.
- busy  out  1  high in STREAM and FLUSH.
- all_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - All outputs are 0.
  - Counters and pipeline valid bits are cleared.
  - Latched weights, bias and mode are cleared.
  - Reset mid-frame abandons the frame; no further writes occur.
- A pixel is accepted on a rising edge where state==STREAM and data_valid_in==1.
- Input counters advance only on accept:
  - col wraps from MAPSIZE-1 to 0 and increments row.
  - A pixel count tracks the total accepted.
- Window-valid condition, evaluated on each accepted pixel at (row r, col c):
  - r>=KSIZE-1 and c>=KSIZE-1, and
  - (r-KSIZE+1)%STRIDE==0 and (c-KSIZE+1)%STRIDE==0.
- Pipeline (3 stages, free-running; it never stalls on input gaps):
  - S1: capture the KxK window, including the newly accepted pixel, plus its valid bit.
  - S2: form the KSIZE*KSIZE signed products, each 2*DATA_W wide.
  - S3: adder tree, sign-extended to ACC_W, plus bias; apply ReLU when latched mode is 1.
  - Output register: write with the data and address.
- Latency: mem_wr_en is high during the cycle following the 4th rising edge after the accepting edge.
- Writes and addressing:
  - mem_wr_en is high for exactly one cycle per valid window.
  - mem_wr_addr runs 0..OUT_COUNT-1 in raster order with no gaps.
  - Outputs are not written while mem_wr_en is 0; their values are don't-care.
- Arithmetic is two's complement with wrap-around at ACC_W; no saturation.
- The row buffer holds KSIZE-1 full lines plus the window registers. It shifts only on accept.
- State machine:
  - IDLE: in_ready=0, busy=0. On start, latch weights, bias and mode_relu, clear counters, go to STREAM.
  - STREAM: accept pixels. On accept of pixel MAPSIZE*MAPSIZE-1, go to FLUSH. in_ready drops on the following cycle.
  - FLUSH: in_ready=0, data_valid_in ignored. Stay until all pipeline valid bits are 0 and the last write has been issued, then go to DONE.
  - DONE: all_done=1 for one cycle, then IDLE.
- Boundary rules:
  - start outside IDLE is ignored.
  - data_valid_in outside STREAM is ignored and does not move counters.
  - Weight, bias or mode changes after start have no effect until the next start.
  - start asserted in the same cycle as the DONE→IDLE transition is not honoured; it is honoured on the next cycle in IDLE.
  - A frame always produces exactly OUT_COUNT writes.
  - Back-to-back frames need a new start; the row buffer contents from the prior frame must not corrupt results. The first-window conditions guarantee this.

Decomposition:
- Package conv_pkg holds:
  - typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} conv_state_t;
  - function out_dim(mapsize, ksize, stride);
  - the constant PIPE_LAT=3.
- One sub-module, line_buffer_kxk (params LENGTH, KSIZE, DATA_W):
  - inputs: clk, rst_n, shift_en, pixel_in.
  - output: window [KSIZE][KSIZE][DATA_W].
  - The window updates on the shift_en edge.
- The MAC tree and control FSM stay in conv_engine_kxk.

Test Plan:
- MAPSIZE=8, KSIZE=3, STRIDE=1; all pixels 1, weights 1, bias 0, relu 0; continuous valid -> 36 writes, addr 0..35, data 9 each, a single all_done pulse, busy low afterwards.
- Same config, STRIDE=2 -> OUT_DIM=3; 9 writes, addr 0..8, data 9. Windows start at rows/cols 0, 2, 4 of the input.
- Pixel value = (r*8+c) mod 128; centre weight 1, others 0; bias 5 -> data at addr k equals the window-centre pixel plus 5. Addr 0 = 9+5=14; addr 35 = 54+5=59.
- Weights all -1, pixels 1, bias 2 -> relu=0 gives -7 for every write; relu=1 gives 0 for every write.
- Same as case 1 with random 0-3 cycle gaps in data_valid_in, and weights changed to 2 after start -> identical results (9) and 36 writes. Per-write latency is 4 edges after the accepting edge.
- Other boundary checks:
  - Assert rst_n low at pixel 30 -> outputs 0 immediately, no further writes.
  - A new start then gives a clean full frame of 36 correct writes.
  - start pulsed during STREAM has no effect.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the KxK convolution engine
package conv_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} conv_state_t;

    localparam int PIPE_LAT = 3;

    function automatic int out_dim(input int mapsize, input int ksize, input int stride);
        return (mapsize - ksize) / stride + 1;
    endfunction

endpackage

// File: rtl/line_buffer_kxk.sv
// line_buffer_kxk: KSIZE-1 raster lines plus a KxK window, shifted one pixel per accept
module line_buffer_kxk
    import conv_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int KSIZE  = 5,
    parameter int DATA_W = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    shift_en,
    input  logic [DATA_W-1:0]                       pixel_in,
    output logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] window
);

    localparam int DEPTH = (KSIZE - 1) * LENGTH + KSIZE;

    logic [DEPTH-1:0][DATA_W-1:0] sr_q;

    // newest pixel enters at tap 0; one line older sits LENGTH taps further on
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sr_q <= '0;
        else if (shift_en)
            sr_q <= {sr_q[DEPTH-2:0], pixel_in};

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            assign window[r][c] = sr_q[(KSIZE-1-r)*LENGTH + (KSIZE-1-c)];
        end
    end

endmodule

// File: rtl/conv_engine_kxk.sv
// conv_engine_kxk: streaming KxK convolution with bias, optional ReLU and BRAM write-out
module conv_engine_kxk
    import conv_pkg::*;
#(
    parameter  int MAPSIZE   = 32,
    parameter  int KSIZE     = 5,
    parameter  int STRIDE    = 1,
    parameter  int DATA_W    = 8,
    parameter  int ACC_W     = 32,
    localparam int OUT_DIM   = out_dim(MAPSIZE, KSIZE, STRIDE),
    localparam int OUT_COUNT = OUT_DIM * OUT_DIM,
    localparam int ADDR_W    = OUT_COUNT > 1 ? $clog2(OUT_COUNT) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    mode_relu,
    input  logic                                    data_valid_in,
    input  logic [DATA_W-1:0]                       pixel_in,
    output logic                                    in_ready,
    input  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] weights,
    input  logic [ACC_W-1:0]                        bias,
    output logic [ADDR_W-1:0]                       mem_wr_addr,
    output logic [ACC_W-1:0]                        mem_wr_data,
    output logic                                    mem_wr_en,
    output logic                                    busy,
    output logic                                    all_done
);

    localparam int CW    = MAPSIZE > 1 ? $clog2(MAPSIZE) : 1;
    localparam int PW    = $clog2(MAPSIZE * MAPSIZE);
    localparam int PRD_W = 2 * DATA_W;
    localparam logic [CW-1:0] KM1   = CW'(KSIZE - 1);
    localparam logic [CW-1:0] COL_L = CW'(MAPSIZE - 1);
    localparam logic [PW-1:0] LAST  = PW'(MAPSIZE * MAPSIZE - 1);

    conv_state_t state_q, state_d;
    logic [CW-1:0] row_q, col_q;
    logic [PW-1:0] pix_q;
    logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] w_q, win, win_q;
    logic [KSIZE-1:0][KSIZE-1:0][PRD_W-1:0] prod_q;
    logic [ACC_W-1:0] bias_q, acc_d, res_d, res_q, data_q;
    logic relu_q, wen_q;
    logic [PIPE_LAT:0] vld_q;
    logic [ADDR_W-1:0] wcnt_q, addr_q;
    logic load, accept, win_ok;

    assign load   = state_q == IDLE && start;
    assign accept = state_q == STREAM && data_valid_in;
    assign win_ok = row_q >= KM1 && col_q >= KM1 &&
                    (STRIDE == 1 || (row_q[0] == KM1[0] && col_q[0] == KM1[0]));

    assign mem_wr_en   = wen_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;

    // next state: FLUSH waits for the pipeline to drain so the tail writes always land
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? STREAM : IDLE;
            STREAM:  state_d = accept && pix_q == LAST ? FLUSH : STREAM;
            FLUSH:   state_d = vld_q == '0 ? DONE : FLUSH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state-decoded handshake and status outputs
    always_comb begin
        in_ready = state_q == STREAM;
        busy     = state_q == STREAM || state_q == FLUSH;
        all_done = state_q == DONE;
    end

    // raster position of the next pixel to be accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            pix_q <= '0;
        end else if (load) begin
            row_q <= '0;
            col_q <= '0;
            pix_q <= '0;
        end else if (accept) begin
            col_q <= col_q == COL_L ? '0 : col_q + 1'b1;
            row_q <= col_q == COL_L ? row_q + 1'b1 : row_q;
            pix_q <= pix_q + 1'b1;
        end

    // frame configuration is frozen at start
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            w_q    <= '0;
            bias_q <= '0;
            relu_q <= 1'b0;
        end else if (load) begin
            w_q    <= weights;
            bias_q <= bias;
            relu_q <= mode_relu;
        end

    line_buffer_kxk #(
        .LENGTH (MAPSIZE),
        .KSIZE  (KSIZE),
        .DATA_W (DATA_W)
    ) u_lb (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .pixel_in (pixel_in),
        .window   (win)
    );

    // free-running pipeline: window capture, products, accumulate; valid bits ride alongside
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vld_q  <= '0;
            win_q  <= '0;
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_LAT-1:0], accept && win_ok};
            win_q <= win;
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE; c++)
                    prod_q[r][c] <= $signed(win_q[r][c]) * $signed(w_q[r][c]);
            res_q <= res_d;
        end

    // adder tree with sign-extended products, bias and optional ReLU clamp
    always_comb begin
        acc_d = bias_q;
        for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
                acc_d = acc_d + {{(ACC_W-PRD_W){prod_q[r][c][PRD_W-1]}}, prod_q[r][c]};
        res_d = relu_q && acc_d[ACC_W-1] ? '0 : acc_d;
    end

    // output register: one strobe per valid window at the next sequential address
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            wcnt_q <= '0;
        end else begin
            wen_q <= vld_q[PIPE_LAT];
            if (load)
                wcnt_q <= '0;
            else if (vld_q[PIPE_LAT]) begin
                addr_q <= wcnt_q;
                data_q <= res_q;
                wcnt_q <= wcnt_q + 1'b1;
            end
        end

endmodule

// File: tb/tb_conv_engine_kxk.sv
// tb_conv_engine_kxk: scoreboard bench for 8x8 / 3x3 engines at stride 1 and 2
module tb_conv_engine_kxk;

    localparam int M = 8;
    localparam int K = 3;

    logic clk = 0, rst_n = 1, start1 = 0, start2 = 0, relu = 0, dv = 0;
    logic [7:0] pix = '0;
    logic [K-1:0][K-1:0][7:0] wp = '0;
    logic [31:0] bp = '0;
    logic rdy1, rdy2, wen1, wen2, busy1, busy2, done1, done2;
    logic [5:0] addr1;
    logic [3:0] addr2;
    logic [31:0] data1, data2;

    typedef struct {int addr; int data; int cyc;} exp_t;
    exp_t q[$];
    int img[M*M];
    int wv[K][K];
    int bias_v;
    bit relu_v;
    int total = 0, bad = 0, nwr, ndone, first_d, last_d, cyc = 0;
    bit aborted;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv_engine_kxk #(.MAPSIZE(M), .KSIZE(K), .STRIDE(1), .DATA_W(8), .ACC_W(32)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode_relu(relu), .data_valid_in(dv),
        .pixel_in(pix), .in_ready(rdy1), .weights(wp), .bias(bp), .mem_wr_addr(addr1),
        .mem_wr_data(data1), .mem_wr_en(wen1), .busy(busy1), .all_done(done1));

    conv_engine_kxk #(.MAPSIZE(M), .KSIZE(K), .STRIDE(2), .DATA_W(8), .ACC_W(32)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode_relu(relu), .data_valid_in(dv),
        .pixel_in(pix), .in_ready(rdy2), .weights(wp), .bias(bp), .mem_wr_addr(addr2),
        .mem_wr_data(data2), .mem_wr_en(wen2), .busy(busy2), .all_done(done2));

    function automatic logic rdy(input int s);
        return s == 2 ? rdy2 : rdy1;
    endfunction

    function automatic int model(input int oy, input int ox, input int st);
        int s = bias_v;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                s += img[(oy*st+ky)*M + ox*st+kx] * wv[ky][kx];
        return (relu_v && s < 0) ? 0 : s;
    endfunction

    task automatic set_cfg(input int pmode, input int w, input bit centre, input int b, input bit rl);
        for (int p = 0; p < M*M; p++) img[p] = pmode == 0 ? 1 : ((p / M) * M + p % M) % 128;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                wv[r][c] = centre ? ((r == 1 && c == 1) ? 1 : 0) : w;
        bias_v = b;
        relu_v = rl;
    endtask

    task automatic run_frame(input int sel, input int gapmax, input bit chg_w, input bit poke, input int abort_at);
        int st, od, k;
        st = sel == 2 ? 2 : 1;
        od = (M - K) / st + 1;
        nwr = 0; ndone = 0; aborted = 0; k = 0; first_d = 0; last_d = 0;
        @(negedge clk);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                int wtmp;
                wtmp = wv[r][c];
                wp[r][c] = wtmp[7:0];
            end
        bp = bias_v;
        relu = relu_v;
        if (sel == 2) start2 = 1; else start1 = 1;
        @(negedge clk);
        start1 = 0; start2 = 0;
        if (chg_w) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    wp[r][c] = 8'd2;
            bp = 32'd99;
            relu = ~relu_v;
        end
        fork
            begin : drv
                for (int p = 0; p < M*M; p++) begin
                    int g, guard, oy, ox;
                    if (p == abort_at) begin
                        dv = 0;
                        rst_n = 0;
                        aborted = 1;
                        break;
                    end
                    g = gapmax > 0 ? int'($urandom_range(gapmax, 0)) : 0;
                    repeat (g) begin
                        dv = 0;
                        @(negedge clk);
                    end
                    dv = 1;
                    pix = img[p][7:0];
                    start1 = poke && p == 20;
                    guard = 0;
                    while (!rdy(sel) && guard < 20) begin
                        @(negedge clk);
                        guard++;
                    end
                    total++;
                    if (rdy(sel) !== 1'b1) begin
                        bad++;
                        $display("FAIL in_ready pixel %0d: got %b want 1", p, rdy(sel));
                    end
                    if (k < od*od) begin
                        oy = k / od;
                        ox = k % od;
                        if (p == (oy*st+K-1)*M + ox*st+K-1) begin
                            q.push_back('{k, model(oy, ox, st), cyc + 5});
                            k++;
                        end
                    end
                    @(negedge clk);
                    start1 = 0;
                end
                dv = 0;
            end
            begin : col
                int t, post;
                t = 0; post = 0;
                while (1) begin
                    logic we, dn;
                    logic [31:0] a, d;
                    @(negedge clk);
                    if (aborted) break;
                    t++;
                    we = sel == 2 ? wen2 : wen1;
                    dn = sel == 2 ? done2 : done1;
                    a = sel == 2 ? 32'(addr2) : 32'(addr1);
                    d = sel == 2 ? data2 : data1;
                    if (we === 1'b1) begin
                        exp_t e;
                        nwr++;
                        total++;
                        if (q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_write: addr %0d data %0d with empty scoreboard", a, $signed(d));
                        end else begin
                            e = q.pop_front();
                            if (nwr == 1) first_d = int'(d);
                            last_d = int'(d);
                            total += 2;
                            if (a !== 32'(e.addr)) begin
                                bad++;
                                $display("FAIL wr_addr: got %0d want %0d", a, e.addr);
                            end
                            if (d !== 32'(e.data)) begin
                                bad++;
                                $display("FAIL wr_data addr %0d: got %0d want %0d", e.addr, $signed(d), e.data);
                            end
                            if (cyc != e.cyc) begin
                                bad++;
                                $display("FAIL wr_latency addr %0d: got edge %0d want %0d", e.addr, cyc, e.cyc);
                            end
                        end
                    end
                    if (dn === 1'b1) ndone++;
                    if (ndone > 0) post++;
                    if (post == 3) break;
                    if (t == 3000) begin
                        total++; bad++;
                        $display("FAIL frame_timeout: got %0d writes %0d done pulses within %0d cycles", nwr, ndone, t);
                        break;
                    end
                end
            end
        join
    endtask

    task automatic check_frame(input string nm, input int sel, input int want);
        total += 4;
        if (nwr !== want) begin bad++; $display("FAIL %s write_count: got %0d want %0d", nm, nwr, want); end
        if (ndone !== 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", nm, ndone); end
        if (q.size() !== 0) begin bad++; $display("FAIL %s leftover_expected: got %0d want 0", nm, q.size()); end
        if ((sel == 2 ? busy2 : busy1) !== 1'b0) begin bad++; $display("FAIL %s busy_after: got 1 want 0", nm); end
        q.delete();
    endtask

    task automatic test_reset;
        #2 rst_n = 0;
        #1;
        total += 7;
        if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", rdy1); end
        if (busy1 !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy1); end
        if (done1 !== 1'b0) begin bad++; $display("FAIL reset all_done: got %b want 0", done1); end
        if (wen1 !== 1'b0) begin bad++; $display("FAIL reset wr_en: got %b want 0", wen1); end
        if (addr1 !== 6'd0) begin bad++; $display("FAIL reset wr_addr: got %h want 0", addr1); end
        if (data1 !== 32'd0) begin bad++; $display("FAIL reset wr_data: got %h want 0", data1); end
        if (wen2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset dut2: got wen %b busy %b want 0 0", wen2, busy2); end
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_ones;
        set_cfg(0, 1, 0, 0, 0);
        run_frame(1, 0, 0, 0, -1);
        total++;
        if (last_d !== 9) begin bad++; $display("FAIL ones last_data: got %0d want 9", last_d); end
        check_frame("ones", 1, 36);
    endtask

    task automatic test_stride2;
        set_cfg(0, 1, 0, 0, 0);
        run_frame(2, 0, 0, 0, -1);
        check_frame("stride2", 2, 9);
    endtask

    task automatic test_centre;
        set_cfg(1, 0, 1, 5, 0);
        run_frame(1, 0, 0, 0, -1);
        total += 2;
        if (first_d !== 14) begin bad++; $display("FAIL centre addr0: got %0d want 14", first_d); end
        if (last_d !== 59) begin bad++; $display("FAIL centre addr35: got %0d want 59", last_d); end
        check_frame("centre", 1, 36);
    endtask

    task automatic test_relu;
        set_cfg(0, -1, 0, 2, 0);
        run_frame(1, 0, 0, 0, -1);
        total++;
        if (last_d !== -7) begin bad++; $display("FAIL relu_off data: got %0d want -7", last_d); end
        check_frame("relu_off", 1, 36);
        set_cfg(0, -1, 0, 2, 1);
        run_frame(1, 0, 0, 0, -1);
        total++;
        if (last_d !== 0) begin bad++; $display("FAIL relu_on data: got %0d want 0", last_d); end
        check_frame("relu_on", 1, 36);
    endtask

    task automatic test_gaps;
        set_cfg(0, 1, 0, 0, 0);
        run_frame(1, 3, 1, 0, -1);
        check_frame("gaps", 1, 36);
    endtask

    task automatic test_start_ignored;
        set_cfg(0, 1, 0, 0, 0);
        run_frame(1, 0, 0, 1, -1);
        check_frame("start_ignored", 1, 36);
    endtask

    task automatic test_abort;
        int stray;
        set_cfg(0, 1, 0, 0, 0);
        run_frame(1, 0, 0, 0, 30);
        #1;
        total += 4;
        if (wen1 !== 1'b0) begin bad++; $display("FAIL abort wr_en: got %b want 0", wen1); end
        if (busy1 !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", busy1); end
        if (rdy1 !== 1'b0) begin bad++; $display("FAIL abort in_ready: got %b want 0", rdy1); end
        if (data1 !== 32'd0 || addr1 !== 6'd0) begin bad++; $display("FAIL abort wr_bus: got %h/%h want 0/0", addr1, data1); end
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (wen1 === 1'b1) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL abort stray_writes: got %0d want 0", stray); end
        test_ones;
    endtask

    initial begin
        test_reset;
        test_ones;
        test_stride2;
        test_centre;
        test_relu;
        test_gaps;
        test_start_ignored;
        test_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
